mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit, directly downstream of the register file read ports.
//  - Consumes the two operand values (rs, rt) read from the GPRs.
//  - Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  - Holds the architectural HI/LO registers that MFHI/MFLO read.
//  - Control stalls on busy.
// PARAMETERS
//  WIDTH      32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled on posedge while idle
//  op         in   3      operation, encodings in mdu_defs.vh
//  operand_a  in   WIDTH  rs value: multiplicand / dividend / MTHI-MTLO source
//  operand_b  in   WIDTH  rt value: multiplier / divisor
//  busy       out  1      high while a mult/div is in progress
//  done       out  1      one-cycle pulse when HI/LO take a mult/div result
//  div_zero   out  1      sticky; set by a DIV or DIVU with divisor 0
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Clocking/reset: one clock. Reset is synchronous and active-high. rst dominates start.
//  Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0.
//  Reset mid-operation aborts the operation; no result is written.
//  Ops (3-bit):
//   - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU: multi-cycle.
//   - 100 MTHI (hi<=operand_a), 101 MTLO (lo<=operand_a): single edge, no busy, no done.
//   - 11x reserved: no state change.
//  Accept rule: start is honoured only in IDLE. Any start while busy=1 is ignored entirely,
//  including MTHI and MTLO.
//  FSM:
//   - IDLE: on start with a mult/div op, latch the operands.
//     - Signed ops latch the magnitudes, plus the negate flags for result and remainder.
//     - Clear cnt and go to CALC.
//   - CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//     cnt runs 0..WIDTH-1; at cnt==WIDTH-1 go to FIX.
//   - FIX: apply the sign corrections, write hi/lo, pulse done, go to IDLE.
//  Latency: start accepted at edge E0 -> hi/lo updated and done=1 after edge E0+WIDTH+1
//  (33 edges at WIDTH=32).
//   - busy=1 from after E0 until that same edge.
//   - busy=0 and done=1 in the same cycle, so back-to-back issue is legal in the done cycle.
//  Mult: {hi,lo} = full 2*WIDTH product. MULT is signed two's complement; MULTU is unsigned.
//  Div: lo=quotient, hi=remainder.
//   - Signed quotient truncates toward zero.
//   - Remainder takes the sign of the dividend.
//   - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
//  Divide by zero (DIV or DIVU, operand_b==0):
//   - Full latency is still used.
//   - Result is lo=all-ones, hi=original operand_a.
//   - div_zero is set and held until rst.
//  hi and lo keep their old values throughout CALC; partial products are never visible.
//  Operand inputs may change freely after the accept edge.
// STRUCTURE
//  Shared include mdu_defs.vh:
//   - MDU_OP_* opcode localparams.
//   - FSM state encodings S_IDLE, S_CALC, S_FIX.
//  One sub-module, mdu_step: the combinational single-iteration datapath.
//   - In: acc, shift register, operand, mode.
//   - Out: next acc and next shift register.
//  The FSM, counter, sign fix-up and HI/LO registers live in mult_div_unit.
// TESTING
//  1. rst high 2 cycles, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF
//     -> done after edge 33, hi=0xFFFFFFFE, lo=0x00000001, busy low in the done cycle.
//  2. MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU a=100 b=7 -> lo=14, hi=2.
//  4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
//     A following DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero still 1.
//  5. MTHI 0xAAAA then MTLO 0x5555 on consecutive edges -> hi/lo update next edge, done=0.
//     MULT started, then MTLO asserted at cycle 5 of CALC -> ignored, final lo = product.
//  6. Start MULT, assert rst at cycle 10 of CALC -> after that edge busy=0, hi=lo=0,
//     no done pulse.
//     Then issue a new start in the done cycle of a prior op
//     -> accepted, second done exactly 33 edges later.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - MDU_OP_* : 3-bit operation encodings on the op port (11x is reserved)
//   - mdu_state_e : control FSM states
//   - op_is_muldiv / op_is_signed : opcode decode helpers
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'b000;
  localparam logic [2:0] MDU_OP_MULTU = 3'b001;
  localparam logic [2:0] MDU_OP_DIV   = 3'b010;
  localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
  localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
  localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  // Multi-cycle ops are exactly the ones with op[2] clear.
  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // MULT and DIV are the signed variants; bit 0 marks the unsigned ones.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// mdu_step: combinational single iteration of the multiply/divide datapath.
//   acc       in  : running high half (mult) / partial remainder (div)
//   sreg      in  : multiplier bits being consumed (mult) / dividend bits
//                   being shifted out with quotient bits shifted in (div)
//   operand   in  : multiplicand (mult) / divisor (div), both unsigned
//   is_div    in  : 1 = restoring shift-subtract, 0 = shift-add
//   acc_next  out : acc after this iteration
//   sreg_next out : sreg after this iteration
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic           fits;

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift {sum, sreg} right by one; the product's low half fills sreg.
    sum     = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor only if it fits.
    partial = {acc, sreg[WIDTH-1]};
    fits    = (partial >= {1'b0, operand});

    acc_next  = sum[WIDTH:1];
    sreg_next = {sum[0], sreg[WIDTH-1:1]};
    if (is_div) begin
      acc_next  = fits ? WIDTH'(partial - {1'b0, operand}) : partial[WIDTH-1:0];
      sreg_next = {sreg[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit fed by the GPR read ports.
//   clk       in  : clock, all state updates on posedge
//   rst       in  : synchronous active-high reset, dominates start
//   start     in  : request, honoured only while idle
//   op        in  : MULT/MULTU/DIV/DIVU (multi-cycle), MTHI/MTLO (single edge)
//   operand_a in  : rs value (multiplicand / dividend / MTHI-MTLO source)
//   operand_b in  : rt value (multiplier / divisor)
//   busy      out : high while a mult/div is in progress
//   done      out : one-cycle pulse when HI/LO take a mult/div result
//   div_zero  out : sticky flag, set by DIV/DIVU with a zero divisor
//   hi, lo    out : architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e state, state_next;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, sreg, oper;
  logic [WIDTH-1:0]   acc_step, sreg_step;
  logic               is_div;
  logic               neg_lo, neg_hi;
  logic               dz_pend;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .sreg      (sreg),
    .operand   (oper),
    .is_div    (is_div),
    .acc_next  (acc_step),
    .sreg_next (sreg_step)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && op_is_muldiv(op)) state_next = S_CALC;
      S_CALC:  if (cnt == CW'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The datapath runs on unsigned magnitudes; signs are restored in FIX.
  always_comb begin
    mag_a = operand_a;
    mag_b = operand_b;
    if (op_is_signed(op) && operand_a[WIDTH-1]) mag_a = -operand_a;
    if (op_is_signed(op) && operand_b[WIDTH-1]) mag_b = -operand_b;
  end

  always_comb begin
    prod_fix = neg_lo ? -{acc, sreg} : {acc, sreg};
    quo_fix  = neg_lo ? -sreg : sreg;
    rem_fix  = neg_hi ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      sreg     <= '0;
      oper     <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz_pend  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                cnt     <= '0;
                acc     <= '0;
                is_div  <= op[1];
                sreg    <= op[1] ? mag_a : mag_b;
                oper    <= op[1] ? mag_b : mag_a;
                neg_lo  <= op_is_signed(op) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                neg_hi  <= op_is_signed(op) && (op[1] ? operand_a[WIDTH-1]
                                          : (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]));
                dz_pend <= op[1] && (operand_b == '0);
              end
              MDU_OP_MTHI: hi <= operand_a;
              MDU_OP_MTLO: lo <= operand_a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc  <= acc_step;
          sreg <= sreg_step;
          cnt  <= cnt + CW'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div) begin
            // A zero divisor leaves acc = |dividend| and the remainder sign
            // fix-up restores the original dividend; only the quotient needs
            // forcing, since the sign flip would otherwise disturb all-ones.
            lo <= dz_pend ? '1 : quo_fix;
            hi <= rem_fix;
            if (dz_pend) div_zero <= 1'b1;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors, a cycle-level reference
// model built from plain 64-bit arithmetic, and hand-computed literal checks.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int e0       = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [64:0] ref_result(input logic [2:0] f_op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] rh, rl;
    logic dz;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f_op)
      3'b000: begin p = 64'(sa * sb); {rh, rl} = p; end
      3'b001: begin p = 64'(a) * 64'(b); {rh, rl} = p; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; rl = 32'hFFFF_FFFF; rh = a;
        end else if (f_op == 3'b010) begin
          q = sa / sb; r = sa % sb;
          rl = 32'(q); rh = 32'(r);
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
    return {dz, rh, rl};
  endfunction

  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
          if (p_dz) m_dz <= 1'b1;
        end
      end else if (start) begin
        if (op <= 3'b011) begin
          {p_dz, p_hi, p_lo} <= ref_result(op, operand_a, operand_b);
          m_cnt <= 33;
        end else if (op == 3'b100) m_hi <= operand_a;
        else if (op == 3'b101) m_lo <= operand_a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic issue(input logic [2:0] i_op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = i_op; operand_a = a; operand_b = b;
    e0 = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_latency"}, 32'(edge_cnt - e0), 32'd33);
    check({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : main
    bit any_done;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dz", {31'd0, div_zero}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // 1. MULTU max * max
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);

    // 2. MULT / MULTU of -3 and 7
    @(negedge clk);
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg");
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done("multu_neg");
    check("multu_neg_hi", hi, 32'h0000_0006);
    check("multu_neg_lo", lo, 32'hFFFF_FFEB);

    // 3. DIV -7/2, DIVU 100/7
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg");
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(3'b011, 32'd100, 32'd7);
    wait_done("divu");
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // 4. divide by zero, then signed overflow divide
    @(negedge clk);
    issue(3'b011, 32'h0000_1234, 32'd0);
    wait_done("divu_zero");
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'h0000_1234);
    check("divu_zero_flag", {31'd0, div_zero}, 32'd1);
    @(negedge clk);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
    check("div_ovf_flag", {31'd0, div_zero}, 32'd1);
    // signed divide by zero with a negative dividend
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFF0, 32'd0);
    wait_done("div_zero_neg");
    check("div_zero_neg_lo", lo, 32'hFFFF_FFFF);
    check("div_zero_neg_hi", hi, 32'hFFFF_FFF0);

    // 5. MTHI / MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 3'b100; operand_a = 32'h0000_AAAA;
    @(negedge clk);
    check("mthi_hi", hi, 32'h0000_AAAA);
    op = 3'b101; operand_a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5555);
    check("mtlo_hi", hi, 32'h0000_AAAA);
    check("mtlo_done", {31'd0, done}, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    // reserved op changes nothing
    start = 1'b1; op = 3'b110; operand_a = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    check("rsvd_hi", hi, 32'h0000_AAAA);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    // MTLO while busy is ignored
    issue(3'b000, 32'd5, 32'hFFFF_FFFA);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b101; operand_a = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy_lo_kept", lo, 32'h0000_5555);
    wait_done("mult_mtlo");
    check("mult_mtlo_hi", hi, 32'hFFFF_FFFF);
    check("mult_mtlo_lo", lo, 32'hFFFF_FFE2);

    // 6. reset mid-operation
    @(negedge clk);
    issue(3'b000, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dz", {31'd0, div_zero}, 32'd0);
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("abort_no_done", {31'd0, any_done}, 32'd0);

    // back-to-back issue in the done cycle
    issue(3'b011, 32'd1000, 32'd33);
    wait_done("b2b_first");
    check("b2b_first_lo", lo, 32'd30);
    check("b2b_first_hi", hi, 32'd10);
    issue(3'b001, 32'h0001_0000, 32'h0001_0000);
    wait_done("b2b_second");
    check("b2b_second_hi", hi, 32'h0000_0001);
    check("b2b_second_lo", lo, 32'h0000_0000);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
